// File: rtl/clock_logic_div_pkg.sv
// Shared types and reset configuration for the fractional-N clock-enable divider.
package clock_logic_div_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_DRAINING = 2'd2
    } div_state_t;

    // Divide-by-1 after reset
    localparam int unsigned DIV_RST_MFI = 1;
    localparam int unsigned DIV_RST_MFN = 0;
    localparam int unsigned DIV_RST_MFD = 1;

endpackage

// File: rtl/clock_logic_sync_n.sv
// N-flop level synchronizer bringing an asynchronous input into the clock domain.
module clock_logic_sync_n #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/clock_logic_frac_divider.sv
// Fractional-N clock-enable generator: periods of mfi or mfi+1 cycles chosen by a
// modulo-mfd accumulator, with glitch-free start/stop and a 4-phase config update.
module clock_logic_frac_divider
    import clock_logic_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             async_resetn,
    input  logic             async_enable,
    output logic             async_enable_ack,
    input  logic             async_update,
    input  logic [WIDTH-1:0] mfi,
    input  logic [WIDTH-1:0] mfn,
    input  logic [WIDTH-1:0] mfd,
    output logic             async_update_ack,
    output logic             div_pulse,
    output logic             cfg_error
);

    localparam int unsigned CW = WIDTH + 1;

    logic             en_s, upd_s, upd_q;
    div_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] mfi_cur, mfn_cur, mfd_cur;
    logic [WIDTH-1:0] pend_mfi, pend_mfn, pend_mfd;
    logic             pending, pending_nx;
    logic             upd_ack_nx, err_nx;

    logic             upd_rise, smp_valid, new_valid, new_invalid, apply;
    logic [WIDTH-1:0] src_mfi, src_mfn, src_mfd;
    logic [WIDTH-1:0] eff_mfi, eff_mfn, eff_mfd, eff_acc;
    logic [CW-1:0]    sum, ld_cnt;
    logic [WIDTH-1:0] ld_acc;
    logic             carry;

    clock_logic_sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clock(clock), .async_resetn(async_resetn), .d(async_enable), .q(en_s)
    );

    clock_logic_sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_upd (
        .clock(clock), .async_resetn(async_resetn), .d(async_update), .q(upd_s)
    );

    // Update decode and the period-load arithmetic, using the new config when it applies now
    always_comb begin
        upd_rise    = upd_s & ~upd_q;
        smp_valid   = (mfi != '0) && (mfd != '0) && (mfn < mfd);
        new_valid   = upd_rise & smp_valid;
        new_invalid = upd_rise & ~smp_valid;
        src_mfi     = new_valid ? mfi : pend_mfi;
        src_mfn     = new_valid ? mfn : pend_mfn;
        src_mfd     = new_valid ? mfd : pend_mfd;
        apply       = (new_valid | pending) & ((state == ST_STOPPED) || (cnt == '0));
        eff_mfi     = apply ? src_mfi : mfi_cur;
        eff_mfn     = apply ? src_mfn : mfn_cur;
        eff_mfd     = apply ? src_mfd : mfd_cur;
        eff_acc     = apply ? '0 : acc;
        sum         = CW'(eff_acc) + CW'(eff_mfn);
        carry       = (sum >= CW'(eff_mfd));
        ld_acc      = carry ? WIDTH'(sum - CW'(eff_mfd)) : WIDTH'(sum);
        ld_cnt      = carry ? CW'(eff_mfi) : (CW'(eff_mfi) - CW'(1));
    end

    // Next state: loads happen on start and on every terminal count that keeps running
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        acc_nx     = eff_acc;
        pending_nx = pending;
        err_nx     = cfg_error;
        upd_ack_nx = upd_s & (async_update_ack | apply | new_invalid);

        case (state)
            ST_STOPPED: begin
                if (en_s) begin
                    state_nx = ST_RUNNING;
                    cnt_nx   = ld_cnt;
                    acc_nx   = ld_acc;
                end
            end
            ST_RUNNING, ST_DRAINING: begin
                if (cnt == '0) begin
                    if (en_s) begin
                        state_nx = ST_RUNNING;
                        cnt_nx   = ld_cnt;
                        acc_nx   = ld_acc;
                    end else begin
                        state_nx = ST_STOPPED;
                    end
                end else begin
                    cnt_nx   = cnt - CW'(1);
                    state_nx = en_s ? ST_RUNNING : ST_DRAINING;
                end
            end
            default: begin
                state_nx = ST_STOPPED;
                cnt_nx   = '0;
            end
        endcase

        if (apply) begin
            pending_nx = 1'b0;
        end else if (new_valid) begin
            pending_nx = 1'b1;
        end

        if (new_invalid) begin
            err_nx = 1'b1;
        end else if (apply) begin
            err_nx = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state            <= ST_STOPPED;
            cnt              <= '0;
            acc              <= '0;
            pending          <= 1'b0;
            upd_q            <= 1'b0;
            mfi_cur          <= WIDTH'(DIV_RST_MFI);
            mfn_cur          <= WIDTH'(DIV_RST_MFN);
            mfd_cur          <= WIDTH'(DIV_RST_MFD);
            pend_mfi         <= WIDTH'(DIV_RST_MFI);
            pend_mfn         <= WIDTH'(DIV_RST_MFN);
            pend_mfd         <= WIDTH'(DIV_RST_MFD);
            cfg_error        <= 1'b0;
            async_update_ack <= 1'b0;
            async_enable_ack <= 1'b0;
            div_pulse        <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            acc              <= acc_nx;
            pending          <= pending_nx;
            upd_q            <= upd_s;
            cfg_error        <= err_nx;
            async_update_ack <= upd_ack_nx;
            async_enable_ack <= (state_nx != ST_STOPPED);
            div_pulse        <= (state_nx != ST_STOPPED) && (cnt_nx == '0);
            if (new_valid) begin
                pend_mfi <= mfi;
                pend_mfn <= mfn;
                pend_mfd <= mfd;
            end
            if (apply) begin
                mfi_cur <= src_mfi;
                mfn_cur <= src_mfn;
                mfd_cur <= src_mfd;
            end
        end
    end

endmodule
